// File: rtl/dma_arbiter_pkg.sv
// Shared types for the DMA channel arbiter: FSM state encoding and small helpers.
package dma_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // A channel owns the controller port only while the grant is live.
  function automatic logic state_routes(input arb_state_t s);
    return (s == ST_GRANT) || (s == ST_BUSY);
  endfunction

endpackage

// File: rtl/dma_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after last_ptr+1, wrapping.
module dma_arbiter_rr_pick #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_ptr,
  output logic [CH_W-1:0]   winner,
  output logic              valid
);

  // Scan farthest-first so the nearest candidate after last_ptr is the final assignment.
  always_comb begin
    int unsigned idx;
    logic [CH_W-1:0] idx_w;
    winner = last_ptr;
    valid  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int unsigned i = NUM_CH; i >= 1; i--) begin
      idx   = (32'(last_ptr) + i) % NUM_CH;
      idx_w = CH_W'(idx);
      if (req[idx_w]) begin
        winner = idx_w;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one dma_controller device port among NUM_CH channels;
// the grant is held for a whole transfer and responses are routed to the winner only.
module dma_arbiter
  import dma_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_W       = 2,
  parameter int unsigned ADD_LEN    = 16,
  parameter int unsigned DATA_LEN   = 16,
  parameter int unsigned FIFO_DEPTH = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH-1:0]            ch_rqst,
  input  logic [NUM_CH-1:0]            ch_rd_wr,
  input  logic [NUM_CH*FIFO_DEPTH-1:0] ch_num_words,
  input  logic [NUM_CH*ADD_LEN-1:0]    ch_start_addr,
  input  logic [NUM_CH-1:0]            ch_dev_ack,
  input  logic [NUM_CH*DATA_LEN-1:0]   ch_dev_in,
  output logic [NUM_CH-1:0]            ch_dma_ack,
  output logic [NUM_CH*DATA_LEN-1:0]   ch_dev_out,
  output logic [NUM_CH-1:0]            ch_end_flag,
  output logic [NUM_CH-1:0]            ch_grant,
  output logic [FIFO_DEPTH-1:0]        num_words,
  output logic [ADD_LEN-1:0]           start_addr,
  output logic                         rd_wr,
  output logic                         rqst,
  output logic                         dev_ack,
  output logic [DATA_LEN-1:0]          dev_in,
  input  logic                         dma_ack,
  input  logic [DATA_LEN-1:0]          dev_out,
  input  logic                         end_flag,
  output logic                         busy,
  output logic [CH_W-1:0]              grant_id
);

  arb_state_t      state_q, state_d;
  logic [CH_W-1:0] grant_id_q, grant_id_d;
  logic [CH_W-1:0] last_ptr_q, last_ptr_d;
  logic [CH_W-1:0] pick_id;
  logic            pick_valid;
  logic            routing;

  logic [FIFO_DEPTH-1:0] nw_arr   [NUM_CH];
  logic [ADD_LEN-1:0]    addr_arr [NUM_CH];
  logic [DATA_LEN-1:0]   din_arr  [NUM_CH];

  dma_arbiter_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .req      (ch_rqst & ch_en),
    .last_ptr (last_ptr_q),
    .winner   (pick_id),
    .valid    (pick_valid)
  );

  // State, grant and pointer registers; last_ptr resets to NUM_CH-1 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      last_ptr_q <= CH_W'(NUM_CH - 1);
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  // Next-state logic; request and mask changes are ignored once a grant is taken.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_ptr_d = last_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_id;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: state_d = ST_BUSY;
      ST_BUSY: begin
        if (end_flag) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        last_ptr_d = grant_id_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign routing  = state_routes(state_q);
  assign busy     = (state_q != ST_IDLE);
  assign rqst     = (state_q == ST_GRANT);
  assign grant_id = grant_id_q;

  // Per-channel unpacking and response demux.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic sel;
    assign nw_arr[k]   = ch_num_words[k*FIFO_DEPTH +: FIFO_DEPTH];
    assign addr_arr[k] = ch_start_addr[k*ADD_LEN +: ADD_LEN];
    assign din_arr[k]  = ch_dev_in[k*DATA_LEN +: DATA_LEN];

    assign sel            = routing && (grant_id_q == CH_W'(k));
    assign ch_grant[k]    = sel;
    assign ch_dma_ack[k]  = sel & dma_ack;
    assign ch_end_flag[k] = sel & end_flag;
    assign ch_dev_out[k*DATA_LEN +: DATA_LEN] = sel ? dev_out : '0;
  end

  // Transfer descriptor follows grant_id so it stays stable for the whole transfer.
  assign num_words  = nw_arr[grant_id_q];
  assign start_addr = addr_arr[grant_id_q];
  assign rd_wr      = ch_rd_wr[grant_id_q];
  assign dev_ack    = routing & ch_dev_ack[grant_id_q];
  assign dev_in     = routing ? din_arr[grant_id_q] : '0;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: a per-cycle vector table plus hand-written sequences.
module tb_dma_arbiter;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int AL     = 16;
  localparam int DL     = 16;
  localparam int FD     = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_en, ch_rqst, ch_rd_wr, ch_dev_ack;
  logic [NUM_CH*FD-1:0] ch_num_words;
  logic [NUM_CH*AL-1:0] ch_start_addr;
  logic [NUM_CH*DL-1:0] ch_dev_in;
  logic [NUM_CH-1:0] ch_dma_ack, ch_end_flag, ch_grant;
  logic [NUM_CH*DL-1:0] ch_dev_out;
  logic [FD-1:0]     num_words;
  logic [AL-1:0]     start_addr;
  logic              rd_wr, rqst, dev_ack, busy;
  logic [DL-1:0]     dev_in, dev_out;
  logic              dma_ack, end_flag;
  logic [CH_W-1:0]   grant_id;

  dma_arbiter #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .ADD_LEN(AL), .DATA_LEN(DL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset),
    .ch_en(ch_en), .ch_rqst(ch_rqst), .ch_rd_wr(ch_rd_wr),
    .ch_num_words(ch_num_words), .ch_start_addr(ch_start_addr),
    .ch_dev_ack(ch_dev_ack), .ch_dev_in(ch_dev_in),
    .ch_dma_ack(ch_dma_ack), .ch_dev_out(ch_dev_out),
    .ch_end_flag(ch_end_flag), .ch_grant(ch_grant),
    .num_words(num_words), .start_addr(start_addr), .rd_wr(rd_wr),
    .rqst(rqst), .dev_ack(dev_ack), .dev_in(dev_in),
    .dma_ack(dma_ack), .dev_out(dev_out), .end_flag(end_flag),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    logic [3:0] rq;
    logic       ack;
    logic       ef;
    logic [3:0] x_grant;
    logic       x_rqst;
    logic       x_busy;
    logic [1:0] x_gid;
    logic [3:0] x_cack;
    logic [3:0] x_cend;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [3:0] en, input logic [3:0] rq,
                              input logic ack, input logic ef,
                              input logic [3:0] g, input logic r, input logic b,
                              input logic [1:0] id, input logic [3:0] ca,
                              input logic [3:0] ce);
    vec_t v;
    v.en = en; v.rq = rq; v.ack = ack; v.ef = ef;
    v.x_grant = g; v.x_rqst = r; v.x_busy = b; v.x_gid = id;
    v.x_cack = ca; v.x_cend = ce;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rqst(input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk); #1;
      cycles++;
    end while (!rqst && cycles < 12);
    chk(name, 64'(rqst), 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, cnt_ack, bad;
    ch_en = '0; ch_rqst = '0; ch_rd_wr = '0; ch_dev_ack = '0;
    ch_num_words = '0; ch_start_addr = '0; ch_dev_in = '0;
    dma_ack = 1'b0; dev_out = '0; end_flag = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_grant", 64'(ch_grant), 0);
    chk("rst_rqst", 64'(rqst), 0);
    chk("rst_gid", 64'(grant_id), 0);
    reset = 1'b0;

    // Round-robin order, dropped request mid-transfer, masked channel, stray end_flag.
    //             en    rq   ack  ef  | grant rqst busy gid cack cend
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h1, 1, 1, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 1, 0, 4'h1, 0, 1, 0, 4'h1, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 1, 4'h1, 0, 1, 0, 4'h0, 4'h1));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h0, 0, 1, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h2, 1, 1, 1, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 1, 4'h2, 0, 1, 1, 4'h0, 4'h2));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h0, 0, 1, 1, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h0, 0, 0, 1, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h4, 1, 1, 2, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 1, 4'h4, 0, 1, 2, 4'h0, 4'h4));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h0, 0, 1, 2, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h0, 0, 0, 2, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h8, 1, 1, 3, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 1, 4'h8, 0, 1, 3, 4'h0, 4'h8));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h0, 0, 1, 3, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h0, 0, 0, 3, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 0, 4'h1, 1, 1, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'hF, 4'h0, 1, 0, 4'h1, 0, 1, 0, 4'h1, 4'h0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 4'h1, 0, 1, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 1, 4'h1, 0, 1, 0, 4'h0, 4'h1));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 0, 4'h4, 1, 1, 2, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 1, 4'h4, 0, 1, 2, 4'h0, 4'h4));
    vecs.push_back(mk(4'hD, 4'hF, 0, 0, 4'h0, 0, 1, 2, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 0, 4'h0, 0, 0, 2, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 0, 4'h8, 1, 1, 3, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 1, 4'h8, 0, 1, 3, 4'h0, 4'h8));
    vecs.push_back(mk(4'hD, 4'hF, 0, 0, 4'h0, 0, 1, 3, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 0, 4'h0, 0, 0, 3, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 0, 4'h1, 1, 1, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 1, 4'h1, 0, 1, 0, 4'h0, 4'h1));
    vecs.push_back(mk(4'hD, 4'hF, 0, 0, 4'h0, 0, 1, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 0, 4'h4, 1, 1, 2, 4'h0, 4'h0));
    vecs.push_back(mk(4'hD, 4'hF, 0, 1, 4'h4, 0, 1, 2, 4'h0, 4'h4));
    vecs.push_back(mk(4'h0, 4'h0, 1, 1, 4'h0, 0, 1, 2, 4'h0, 4'h0));
    vecs.push_back(mk(4'h0, 4'h0, 1, 1, 4'h0, 0, 0, 2, 4'h0, 4'h0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 1, 4'h0, 0, 0, 2, 4'h0, 4'h0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 2, 4'h0, 4'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      ch_en = vecs[i].en; ch_rqst = vecs[i].rq;
      dma_ack = vecs[i].ack; end_flag = vecs[i].ef;
      #1;
      chk($sformatf("v%0d_grant", i), 64'(ch_grant), 64'(vecs[i].x_grant));
      chk($sformatf("v%0d_rqst", i), 64'(rqst), 64'(vecs[i].x_rqst));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].x_busy));
      chk($sformatf("v%0d_gid", i), 64'(grant_id), 64'(vecs[i].x_gid));
      chk($sformatf("v%0d_cack", i), 64'(ch_dma_ack), 64'(vecs[i].x_cack));
      chk($sformatf("v%0d_cend", i), 64'(ch_end_flag), 64'(vecs[i].x_cend));
    end
    dma_ack = 1'b0; end_flag = 1'b0;

    // Single-channel read on channel 2; other channels carry decoy descriptors.
    @(negedge clk);
    reset = 1'b1;
    ch_en = 4'hF; ch_rqst = 4'b0100;
    ch_rd_wr = 4'b0100;
    ch_num_words  = {5'd9, 5'd4, 5'd7, 5'd3};
    ch_start_addr = {16'h3333, 16'h0200, 16'h1111, 16'h0999};
    ch_dev_in     = {16'h4444, 16'hABCD, 16'h2222, 16'h1234};
    ch_dev_ack    = 4'b0101;
    @(negedge clk);
    reset = 1'b0;
    wait_rqst("a_rqst", cyc);
    chk("a_num_words", 64'(num_words), 64'd4);
    chk("a_start_addr", 64'(start_addr), 64'h0200);
    chk("a_rd_wr", 64'(rd_wr), 64'd1);
    chk("a_gid", 64'(grant_id), 64'd2);
    ch_rqst = 4'b0000;
    cnt_ack = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dma_ack = 1'((i % 2) == 1);
      dev_out = 16'h5A00 + 16'(i);
      #1;
      if (ch_dma_ack[2]) cnt_ack++;
      if ((ch_dma_ack & 4'b1011) != 4'b0000 || ch_end_flag != 4'b0000) bad++;
      if (ch_dev_out[47:32] !== dev_out) bad++;
      if (ch_dev_out[31:0] !== 32'h0 || ch_dev_out[63:48] !== 16'h0) bad++;
    end
    chk("a_ack_pulses", 64'(cnt_ack), 64'd4);
    chk("a_route_errs", 64'(bad), 64'd0);
    chk("a_dev_in", 64'(dev_in), 64'hABCD);
    chk("a_dev_ack", 64'(dev_ack), 64'd1);
    chk("a_num_words_hold", 64'(num_words), 64'd4);
    @(negedge clk);
    dma_ack = 1'b0; end_flag = 1'b1;
    #1;
    chk("a_end", 64'(ch_end_flag), 64'b0100);
    @(negedge clk);
    end_flag = 1'b0;
    #1;
    chk("a_rel_end", 64'(ch_end_flag), 64'd0);
    chk("a_rel_dev_in", 64'(dev_in), 64'd0);
    chk("a_rel_dev_ack", 64'(dev_ack), 64'd0);
    chk("a_rel_busy", 64'(busy), 64'd1);
    @(negedge clk); #1;
    chk("a_idle_busy", 64'(busy), 64'd0);

    // Channel 3 alone re-requests right after its end: new rqst exactly 3 cycles after end_flag.
    ch_rqst = 4'b1000;
    wait_rqst("b_rqst1", cyc);
    chk("b_gid1", 64'(grant_id), 64'd3);
    @(negedge clk);
    end_flag = 1'b1;
    @(negedge clk);
    end_flag = 1'b0;
    #1;
    cyc = 1;
    while (!rqst && cyc < 12) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("b_turnaround", 64'(cyc), 64'd3);
    chk("b_gid2", 64'(grant_id), 64'd3);

    // Reset during BUSY: idle next cycle, then channel 0 wins with everything requesting.
    @(negedge clk); #1;
    chk("c_in_busy", 64'(ch_grant), 64'b1000);
    @(negedge clk);
    reset = 1'b1; ch_rqst = 4'hF;
    @(negedge clk); #1;
    chk("c_rst_grant", 64'(ch_grant), 64'd0);
    chk("c_rst_rqst", 64'(rqst), 64'd0);
    chk("c_rst_busy", 64'(busy), 64'd0);
    chk("c_rst_gid", 64'(grant_id), 64'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("c_next_rqst", 64'(rqst), 64'd1);
    chk("c_next_grant", 64'(ch_grant), 64'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
